// File: rtl/tdm_demux_16_pkg.sv
// Shared definitions for the 16-channel TDM receive demultiplexer.
//   NUM_CH  : channel slots per frame
//   CH_BITS : width of the channel index
//   state_t : frame-lock state (HUNT = searching for sync, RUN = locked)
package tdm_demux_16_pkg;

    localparam int NUM_CH  = 16;
    localparam int CH_BITS = 4;

    typedef enum logic {
        HUNT = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/tdm_demux_16_demux_1x4.sv
// One-hot 1:4 decoder used as a node of the slot write-enable tree.
// Ports:
//   en : node enable; all outputs low when en is low
//   S  : 2-bit select
//   Y  : one-hot output, Y[S] = en
module demux_1x4 (
    input  logic       en,
    input  logic [1:0] S,
    output logic [3:0] Y
);

    always_comb begin
        Y = '0;
        if (en) begin
            Y[S] = 1'b1;
        end
    end

endmodule

// File: rtl/tdm_demux_16.sv
// Time-division demultiplexer: receives a serial stream of W-bit words,
// one channel slot per accepted word, locks on a frame-sync marker that
// accompanies channel 0, and presents each completed 16-channel frame in
// parallel with a one-cycle valid pulse.
//
// Handshake: a word on D is consumed on every rising clk edge where D_valid
// is high (there is no back-pressure); sync is only meaningful together with
// D_valid. O_valid and sync_err are single-cycle pulses registered one cycle
// after the word that caused them.
//
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   D         : incoming slot data
//   D_valid   : D carries a word this cycle
//   sync      : D is channel 0 of a new frame
//   O         : last complete frame, channel k at O[k*W +: W]
//   O_valid   : O was just updated
//   ch        : channel index the next accepted word goes to
//   locked    : FSM state (high in RUN)
//   sync_err  : sync arrived mid-frame, partial frame dropped
module tdm_demux_16
    import tdm_demux_16_pkg::*;
#(
    parameter int W = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [W-1:0]          D,
    input  logic                  D_valid,
    input  logic                  sync,
    output logic [NUM_CH*W-1:0]   O,
    output logic                  O_valid,
    output logic [CH_BITS-1:0]    ch,
    output logic                  locked,
    output logic                  sync_err
);

    state_t               state, state_next;
    logic [CH_BITS-1:0]   ch_q, ch_next;
    logic                 o_valid_next;
    logic                 sync_err_next;

    logic                 accept;
    logic [CH_BITS-1:0]   wr_ch;
    logic [3:0]           grp_en;
    logic [NUM_CH-1:0]    slot_en;
    logic                 frame_done;

    // Slot 15 is never stored: the last word goes straight into O.
    logic [W-1:0]              slot [NUM_CH-1];
    logic [(NUM_CH-1)*W-1:0]   slot_flat;
    logic [NUM_CH*W-1:0]       o_q;

    // A word is taken in RUN always, in HUNT only when it carries sync.
    // A synced word always lands in slot 0, whatever ch currently says.
    always_comb begin
        accept = D_valid && ((state == RUN) || sync);
        wr_ch  = (D_valid && sync) ? '0 : ch_q;
    end

    // Two-level demux tree: ch[3:2] picks the group, ch[1:0] the slot.
    demux_1x4 u_lvl1 (
        .en (accept),
        .S  (wr_ch[3:2]),
        .Y  (grp_en)
    );

    for (genvar g = 0; g < 4; g++) begin : g_lvl2
        demux_1x4 u_lvl2 (
            .en (grp_en[g]),
            .S  (wr_ch[1:0]),
            .Y  (slot_en[g*4 +: 4])
        );
    end

    // Slot 15 is only enabled by a non-sync word at ch==15, i.e. the
    // 16th word of an uninterrupted frame.
    assign frame_done = slot_en[NUM_CH-1];

    always_comb begin
        state_next    = state;
        ch_next       = ch_q;
        o_valid_next  = 1'b0;
        sync_err_next = 1'b0;
        case (state)
            HUNT: begin
                if (D_valid && sync) begin
                    state_next = RUN;
                    ch_next    = CH_BITS'(1);
                end
            end
            RUN: begin
                if (D_valid) begin
                    if (sync) begin
                        // Restart the frame; earlier slots are simply
                        // overwritten before the next transfer.
                        ch_next       = CH_BITS'(1);
                        sync_err_next = (ch_q != '0);
                    end else begin
                        ch_next      = ch_q + CH_BITS'(1);
                        o_valid_next = frame_done;
                    end
                end
            end
            default: begin
                state_next = HUNT;
                ch_next    = '0;
            end
        endcase
    end

    always_comb begin
        slot_flat = '0;
        for (int k = 0; k < NUM_CH-1; k++) begin
            slot_flat[k*W +: W] = slot[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= HUNT;
            ch_q     <= '0;
            O_valid  <= 1'b0;
            sync_err <= 1'b0;
            o_q      <= '0;
            for (int k = 0; k < NUM_CH-1; k++) begin
                slot[k] <= '0;
            end
        end else begin
            state    <= state_next;
            ch_q     <= ch_next;
            O_valid  <= o_valid_next;
            sync_err <= sync_err_next;
            for (int k = 0; k < NUM_CH-1; k++) begin
                if (slot_en[k]) begin
                    slot[k] <= D;
                end
            end
            if (frame_done) begin
                o_q <= {D, slot_flat};
            end
        end
    end

    assign O      = o_q;
    assign ch     = ch_q;
    assign locked = (state == RUN);

endmodule

// File: tb/tb_tdm_demux_16.sv
module tb_tdm_demux_16;
  localparam int W = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [W-1:0]    D = '0;
  logic            D_valid = 1'b0;
  logic            sync = 1'b0;
  logic [16*W-1:0] O;
  logic            O_valid;
  logic [3:0]      ch;
  logic            locked;
  logic            sync_err;

  int n_checks = 0;
  int n_fail = 0;
  int ovalid_cnt = 0;
  int serr_cnt = 0;
  logic [63:0] exp_q[$];
  logic [63:0] last_o = '0;

  tdm_demux_16 #(.W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .D        (D),
    .D_valid  (D_valid),
    .sync     (sync),
    .O        (O),
    .O_valid  (O_valid),
    .ch       (ch),
    .locked   (locked),
    .sync_err (sync_err)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pack(input logic [3:0] w[16]);
    logic [63:0] p;
    p = '0;
    for (int i = 0; i < 16; i++) p[i*4 +: 4] = w[i];
    return p;
  endfunction

  // driver tasks: inputs change on the falling edge
  task automatic send(input logic [3:0] d, input logic s);
    @(negedge clk);
    D = d;
    D_valid = 1'b1;
    sync = s;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      D = 4'($urandom_range(0, 15));
      D_valid = 1'b0;
      sync = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    D_valid = 1'b0;
    sync = 1'b0;
    idle(2);
    rst = 1'b0;
  endtask

  task automatic send_frame(input logic [3:0] w[16], input logic first_sync, input int gap);
    exp_q.push_back(pack(w));
    for (int i = 0; i < 16; i++) begin
      send(w[i], first_sync && (i == 0));
      if (gap > 0) idle(gap);
    end
  endtask

  // scoreboard: compare every frame pulse, and require O to hold otherwise
  always @(posedge clk) begin
    #1;
    if (rst) begin
      check_val("rst_O", O, 64'h0);
      check_val("rst_O_valid", 64'(O_valid), 64'h0);
      check_val("rst_sync_err", 64'(sync_err), 64'h0);
      last_o = '0;
    end else begin
      if (sync_err) serr_cnt++;
      if (O_valid) begin
        ovalid_cnt++;
        if (exp_q.size() == 0) check_val("unexpected_frame", 64'h1, 64'h0);
        else check_val("frame", O, exp_q.pop_front());
        last_o = O;
      end else begin
        check_val("O_hold", O, last_o);
      end
    end
  end

  initial begin
    logic [3:0] w[16];
    logic [3:0] w2[16];
    int c_ov;
    int c_se;

    // T1: reset, then frame 0..15 with sync
    idle(2);
    check_val("rst_ch", 64'(ch), 64'h0);
    check_val("rst_locked", 64'(locked), 64'h0);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) w[i] = 4'(i);
    c_ov = ovalid_cnt;
    send_frame(w, 1'b1, 0);
    idle(1);
    check_val("t1_latency", 64'(O_valid), 64'h1);
    check_val("t1_O", O, 64'hFEDCBA9876543210);
    idle(1);
    check_val("t1_pulse_width", 64'(O_valid), 64'h0);
    check_val("t1_locked", 64'(locked), 64'h1);
    check_val("t1_ch", 64'(ch), 64'h0);
    check_val("t1_count", 64'(ovalid_cnt - c_ov), 64'h1);

    // T2: HUNT ignores words without sync
    do_reset();
    check_val("t2_locked_after_rst", 64'(locked), 64'h0);
    c_ov = ovalid_cnt;
    for (int i = 0; i < 5; i++) send(4'($urandom_range(0, 15)), 1'b0);
    idle(1);
    check_val("t2_hunt_ch", 64'(ch), 64'h0);
    check_val("t2_hunt_locked", 64'(locked), 64'h0);
    for (int i = 0; i < 16; i++) w[i] = 4'hA;
    send_frame(w, 1'b1, 0);
    idle(2);
    check_val("t2_O", O, 64'hAAAAAAAAAAAAAAAA);
    check_val("t2_count", 64'(ovalid_cnt - c_ov), 64'h1);

    // T3: gapped input, second frame without sync
    c_ov = ovalid_cnt;
    for (int i = 0; i < 16; i++) w[i] = 4'($urandom_range(0, 15));
    for (int i = 0; i < 16; i++) w2[i] = 4'($urandom_range(0, 15));
    send_frame(w, 1'b1, 1);
    send_frame(w2, 1'b0, 1);
    idle(2);
    check_val("t3_O", O, pack(w2));
    check_val("t3_count", 64'(ovalid_cnt - c_ov), 64'h2);

    // T4: sync after 7 words aborts the partial frame
    c_ov = ovalid_cnt;
    c_se = serr_cnt;
    for (int i = 0; i < 7; i++) send(4'($urandom_range(0, 15)), 1'b0);
    send(4'h3, 1'b1);
    idle(1);
    check_val("t4_sync_err", 64'(sync_err), 64'h1);
    check_val("t4_ch", 64'(ch), 64'h1);
    check_val("t4_locked", 64'(locked), 64'h1);
    idle(1);
    check_val("t4_sync_err_pulse", 64'(sync_err), 64'h0);
    exp_q.push_back(64'hFEDCBA9876543213);
    for (int i = 1; i < 16; i++) send(4'(i), 1'b0);
    idle(2);
    check_val("t4_O", O, 64'hFEDCBA9876543213);
    check_val("t4_count", 64'(ovalid_cnt - c_ov), 64'h1);
    check_val("t4_serr_count", 64'(serr_cnt - c_se), 64'h1);

    // T5: reset after 10 words, then a full frame
    c_ov = ovalid_cnt;
    c_se = serr_cnt;
    for (int i = 0; i < 10; i++) send(4'($urandom_range(0, 15)), 1'b0);
    do_reset();
    idle(2);
    check_val("t5_O_cleared", O, 64'h0);
    check_val("t5_locked", 64'(locked), 64'h0);
    check_val("t5_ch", 64'(ch), 64'h0);
    check_val("t5_no_frame", 64'(ovalid_cnt - c_ov), 64'h0);
    check_val("t5_no_serr", 64'(serr_cnt - c_se), 64'h0);
    for (int i = 0; i < 16; i++) w[i] = 4'($urandom_range(0, 15));
    send_frame(w, 1'b1, 0);
    idle(2);
    check_val("t5_O", O, pack(w));
    check_val("t5_count", 64'(ovalid_cnt - c_ov), 64'h1);

    // T6: sync with D_valid low is ignored
    c_ov = ovalid_cnt;
    c_se = serr_cnt;
    for (int i = 0; i < 16; i++) w[i] = 4'($urandom_range(0, 15));
    exp_q.push_back(pack(w));
    for (int i = 0; i < 5; i++) send(w[i], 1'b0);
    @(negedge clk);
    D_valid = 1'b0;
    sync = 1'b1;
    idle(1);
    check_val("t6_sync_err", 64'(sync_err), 64'h0);
    check_val("t6_ch", 64'(ch), 64'h5);
    for (int i = 5; i < 16; i++) send(w[i], 1'b0);
    idle(2);
    check_val("t6_O", O, pack(w));
    check_val("t6_count", 64'(ovalid_cnt - c_ov), 64'h1);
    check_val("t6_serr_count", 64'(serr_cnt - c_se), 64'h0);

    idle(2);
    check_val("queue_empty", 64'(exp_q.size()), 64'h0);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
